// File: rtl/pri_iter_if.sv
// pri_iter_if: request-vector input and index-beat output handshake bundle
interface pri_iter_if #(parameter int W = 32);
    localparam int IW = $clog2(W);
    logic          i_vld;
    logic [W-1:0]  i_x;
    logic          o_rdy;
    logic          o_vld;
    logic [IW-1:0] o_idx;
    logic [W-1:0]  o_oh;
    logic [IW-1:0] o_seq;
    logic          o_last;
    logic          i_rdy;
    modport slave (input i_vld, i_x, i_rdy, output o_rdy, o_vld, o_idx, o_oh, o_seq, o_last);
    modport master (output i_vld, i_x, i_rdy, input o_rdy, o_vld, o_idx, o_oh, o_seq, o_last);
endinterface

// File: rtl/pri_iter.sv
// pri_iter: walks a request vector and emits the index of each set bit, highest priority first
module pri_iter #(
    parameter int W        = 32,
    parameter bit FROM_LSB = 1'b0
) (
    input logic       i_clk,
    input logic       i_arst,
    pri_iter_if.slave bus
);
    localparam int IW = $clog2(W);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t        state, state_nxt;
    logic [W-1:0]  r, r_nxt, sel;
    logic [IW-1:0] seq, seq_nxt, enc;
    logic          busy, last, rdy, acc, beat;
    // priority select of the residual; later hits override earlier ones, so scan order sets priority
    always_comb begin
        sel = '0;
        enc = '0;
        for (int i = 0; i < W; i++) begin
            if (r[FROM_LSB ? W - 1 - i : i]) begin
                sel = '0;
                sel[FROM_LSB ? W - 1 - i : i] = 1'b1;
                enc = IW'(FROM_LSB ? W - 1 - i : i);
            end
        end
    end
    // handshake decode and next-state: a last-beat handshake may accept a new vector in the same cycle
    always_comb begin
        busy      = state == BUSY;
        last      = busy && (r & ~sel) == '0;
        rdy       = !busy || (last && bus.i_rdy);
        acc       = bus.i_vld && rdy;
        beat      = busy && bus.i_rdy;
        state_nxt = state;
        r_nxt     = r;
        seq_nxt   = seq;
        if (beat && !last) begin
            r_nxt   = r & ~sel;
            seq_nxt = seq + 1'b1;
        end
        if (acc) begin
            state_nxt = bus.i_x != '0 ? BUSY : IDLE;
            r_nxt     = bus.i_x;
            seq_nxt   = '0;
        end else if (beat && last) begin
            state_nxt = IDLE;
            r_nxt     = '0;
            seq_nxt   = '0;
        end
    end
    // state register; reset discards any residual vector
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state <= IDLE;
            r     <= '0;
            seq   <= '0;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
            seq   <= seq_nxt;
        end
    end
    assign bus.o_rdy  = rdy;
    assign bus.o_vld  = busy;
    assign bus.o_oh   = busy ? sel : '0;
    assign bus.o_idx  = busy ? enc : '0;
    assign bus.o_seq  = busy ? seq : '0;
    assign bus.o_last = last;
endmodule

// File: tb/tb_pri_iter.sv
// tb_pri_iter: directed and randomized checks of pri_iter in both priority directions
module tb_pri_iter;
    typedef int iq_t[$];
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] x   = 8'h00;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    pri_iter_if #(.W(8)) bm ();
    pri_iter_if #(.W(8)) bl ();
    assign bm.i_vld = vld;
    assign bm.i_x   = x;
    assign bm.i_rdy = rdy;
    assign bl.i_vld = vld;
    assign bl.i_x   = x;
    assign bl.i_rdy = rdy;

    pri_iter #(.W(8), .FROM_LSB(1'b0)) u_msb (.i_clk(clk), .i_arst(rst), .bus(bm));
    pri_iter #(.W(8), .FROM_LSB(1'b1)) u_lsb (.i_clk(clk), .i_arst(rst), .bus(bl));

    // expected {vld, idx, oh, seq, last, rdy}
    function automatic logic [16:0] exp_of(input bit v, input int idx, input int sq, input bit lst, input bit rd);
        logic [7:0] oh;
        oh = 8'd1 << idx;
        return v ? {1'b1, 3'(idx), oh, 3'(sq), lst, rd} : {1'b0, 3'd0, 8'd0, 3'd0, 1'b0, rd};
    endfunction

    function automatic logic [16:0] got_m();
        return {bm.o_vld, bm.o_idx, bm.o_oh, bm.o_seq, bm.o_last, bm.o_rdy};
    endfunction

    function automatic logic [16:0] got_l();
        return {bl.o_vld, bl.o_idx, bl.o_oh, bl.o_seq, bl.o_last, bl.o_rdy};
    endfunction

    // set-bit indices of v in service order
    function automatic iq_t order(input logic [7:0] v, input bit lsb);
        iq_t q;
        for (int i = 0; i < 8; i++) begin
            int b = lsb ? i : 7 - i;
            if (v[b]) q.push_back(b);
        end
        return q;
    endfunction

    task automatic test_reset();
        logic [16:0] e;
        vld = 1'b1;
        x   = 8'hFF;
        rdy = 1'b1;
        @(negedge clk);
        #1;
        e = exp_of(0, 0, 0, 0, 1);
        if (got_m() !== e) begin bad++; $display("FAIL reset_hold_msb got=%h want=%h", got_m(), e); end
        total++;
        if (got_l() !== e) begin bad++; $display("FAIL reset_hold_lsb got=%h want=%h", got_l(), e); end
        total++;
        @(negedge clk);
        rst = 1'b0;
        vld = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            if (got_m() !== e) begin bad++; $display("FAIL reset_release%0d got=%h want=%h", c, got_m(), e); end
            total++;
        end
    endtask

    task automatic test_msb_basic();
        int          ei[3] = '{7, 5, 2};
        logic [16:0] e;
        @(negedge clk);
        vld = 1'b1;
        x   = 8'hA4;
        rdy = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            e = exp_of(1, ei[k], k, k == 2, k == 2);
            if (got_m() !== e) begin bad++; $display("FAIL msb_basic beat%0d got=%h want=%h", k, got_m(), e); end
            total++;
            @(negedge clk);
        end
        #1;
        e = exp_of(0, 0, 0, 0, 1);
        if (got_m() !== e) begin bad++; $display("FAIL msb_basic idle got=%h want=%h", got_m(), e); end
        total++;
    endtask

    task automatic test_lsb_basic();
        int          ei[3] = '{2, 5, 7};
        logic [16:0] e;
        @(negedge clk);
        vld = 1'b1;
        x   = 8'hA4;
        rdy = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            e = exp_of(1, ei[k], k, k == 2, k == 2);
            if (got_l() !== e) begin bad++; $display("FAIL lsb_basic beat%0d got=%h want=%h", k, got_l(), e); end
            total++;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] e;
        @(negedge clk);
        vld = 1'b1;
        x   = 8'hC0;
        rdy = 1'b0;
        @(negedge clk);
        vld = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) rdy = 1'b1;
            #1;
            e = exp_of(1, 7, 0, 0, 0);
            if (got_m() !== e) begin bad++; $display("FAIL backpressure cyc%0d got=%h want=%h", c, got_m(), e); end
            total++;
            @(negedge clk);
        end
        #1;
        e = exp_of(1, 6, 1, 1, 1);
        if (got_m() !== e) begin bad++; $display("FAIL backpressure last got=%h want=%h", got_m(), e); end
        total++;
    endtask

    task automatic test_zero();
        logic [16:0] e;
        @(negedge clk);
        vld = 1'b1;
        x   = 8'h00;
        rdy = 1'b1;
        @(negedge clk);
        x = 8'h10;
        #1;
        e = exp_of(0, 0, 0, 0, 1);
        if (got_m() !== e) begin bad++; $display("FAIL zero_drop got=%h want=%h", got_m(), e); end
        total++;
        @(negedge clk);
        vld = 1'b0;
        #1;
        e = exp_of(1, 4, 0, 1, 1);
        if (got_m() !== e) begin bad++; $display("FAIL zero_next got=%h want=%h", got_m(), e); end
        total++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        @(negedge clk);
        vld = 1'b1;
        x   = 8'h01;
        rdy = 1'b1;
        @(negedge clk);
        x = 8'h80;
        #1;
        e = exp_of(1, 0, 0, 1, 1);
        if (got_m() !== e) begin bad++; $display("FAIL b2b_first got=%h want=%h", got_m(), e); end
        total++;
        @(negedge clk);
        vld = 1'b0;
        #1;
        e = exp_of(1, 7, 0, 1, 1);
        if (got_m() !== e) begin bad++; $display("FAIL b2b_second got=%h want=%h", got_m(), e); end
        total++;
        @(negedge clk);
        #1;
        e = exp_of(0, 0, 0, 0, 1);
        if (got_m() !== e) begin bad++; $display("FAIL b2b_idle got=%h want=%h", got_m(), e); end
        total++;
    endtask

    task automatic test_reset_mid();
        logic [16:0] e;
        @(negedge clk);
        vld = 1'b1;
        x   = 8'hFF;
        rdy = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        #1;
        e = exp_of(1, 7, 0, 0, 0);
        if (got_m() !== e) begin bad++; $display("FAIL rstmid_beat0 got=%h want=%h", got_m(), e); end
        total++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        e = exp_of(0, 0, 0, 0, 1);
        if (got_m() !== e) begin bad++; $display("FAIL rstmid_async got=%h want=%h", got_m(), e); end
        total++;
        @(negedge clk);
        rst = 1'b0;
        vld = 1'b1;
        x   = 8'h02;
        @(negedge clk);
        vld = 1'b0;
        #1;
        e = exp_of(1, 1, 0, 1, 1);
        if (got_m() !== e) begin bad++; $display("FAIL rstmid_new got=%h want=%h", got_m(), e); end
        total++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            e = exp_of(0, 0, 0, 0, 1);
            if (got_m() !== e) begin bad++; $display("FAIL rstmid_noreplay%0d got=%h want=%h", c, got_m(), e); end
            total++;
        end
    endtask

    task automatic test_random();
        iq_t         qm, ql;
        int          sm = 0;
        bit          acc;
        logic [16:0] em, el;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rdy = $urandom_range(0, 3) != 0;
            vld = $urandom_range(0, 1) != 0;
            x   = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
            #1;
            em = qm.size() == 0 ? exp_of(0, 0, 0, 0, 1) : exp_of(1, qm[0], sm, qm.size() == 1, qm.size() == 1 && rdy);
            el = ql.size() == 0 ? exp_of(0, 0, 0, 0, 1) : exp_of(1, ql[0], sm, ql.size() == 1, ql.size() == 1 && rdy);
            if (got_m() !== em) begin bad++; $display("FAIL random_msb cyc%0d got=%h want=%h", c, got_m(), em); end
            total++;
            if (got_l() !== el) begin bad++; $display("FAIL random_lsb cyc%0d got=%h want=%h", c, got_l(), el); end
            total++;
            acc = vld && (qm.size() == 0 || (qm.size() == 1 && rdy));
            if (qm.size() != 0 && rdy) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
                sm++;
            end
            if (acc) begin
                qm = order(x, 1'b0);
                ql = order(x, 1'b1);
                sm = 0;
            end
        end
        @(negedge clk);
        vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_msb_basic();
        test_lsb_basic();
        test_backpressure();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pri_iter.md
# pri_iter

Sequential priority iterator. Accepts a W-bit request vector over a valid/ready handshake and emits the binary index of every set bit, one beat per cycle, highest priority first, with a last flag on the final beat. It is the encoding counterpart of the combinational one-hot priority selector: the selector reduces a vector to a one-hot grant, and this block walks the whole vector and turns each grant into an index for downstream consumers such as scoreboards and completion walkers.

## Interface
- W, 32: request vector width; W >= 2.
- FROM_LSB, 'b0: priority direction; 0 means bit W-1 has highest priority, 1 means bit 0 has highest priority.
- IW (localparam), $clog2(W): index width.

Ports:
- i_clk  in  1  clock; all state is rising-edge.
- i_arst  in  1  reset, asynchronous, active-high.
- i_vld  in  1  input vector valid.
- i_x  in  W  request vector.
- o_rdy  out  1  block can accept a vector.
- o_vld  out  1  output beat valid.
- o_idx  out  IW  index of the current highest-priority remaining bit.
- o_oh  out  W  one-hot form of o_idx.
- o_seq  out  IW  beat number within the current vector, starting at 0.
- o_last  out  1  current beat is the final set bit of the vector.
- i_rdy  in  1  downstream accepts the beat.

## Operation
- State: residual register r[W-1:0], beat counter seq[IW-1:0], and FSM {IDLE, BUSY}. Reset puts the FSM in IDLE with r=0 and seq=0.
- Input handshake: a vector is accepted when i_vld & o_rdy.
- o_rdy = (state==IDLE) | (o_vld & o_last & i_rdy).
- IDLE, accept with i_x!=0: r<=i_x, seq<=0, go to BUSY.
- IDLE, accept with i_x==0: the vector is consumed and dropped. No beat is emitted and the FSM stays in IDLE.
- BUSY: o_vld=1. o_oh is the priority select of r using direction FROM_LSB. o_idx is the binary encoding of o_oh. o_seq=seq. o_last=(r & ~o_oh)==0.
- BUSY, beat handshake (o_vld & i_rdy) with o_last=0: r<=r & ~o_oh and seq<=seq+1. State stays BUSY.
- BUSY, beat handshake with o_last=1:
  - If a new vector is accepted in the same cycle (i_vld=1), apply the IDLE accept rules to it. A nonzero vector keeps the FSM in BUSY with r<=i_x and seq<=0. A zero vector sends the FSM to IDLE with r<=0.
  - Otherwise go to IDLE with r<=0.
- BUSY without i_rdy: r, seq, and every output stay constant.
- The number of beats equals popcount(i_x). seq never wraps because at most W beats are emitted and the maximum value is W-1.
- In IDLE: o_vld=0, and o_idx, o_oh, o_seq, o_last are 0.
- Reset mid-operation: the residual vector is discarded. No partial beats are replayed after reset.

## Timing
- Reset values: o_vld=0, o_idx=0, o_oh=0, o_seq=0, o_last=0, o_rdy=1. The state is IDLE, so o_rdy reads 1 even while i_arst is high; any transfer attempted during reset is ignored.
- Latency: a vector accepted at edge N produces its first beat (o_vld=1) in cycle N+1. Beat k appears no earlier than cycle N+1+k.
- Throughput: one beat per cycle while i_rdy=1. Back-to-back vectors have no bubble because a new vector is accepted on the last-beat handshake.
- The outputs are a combinational function of registered state only. The single combinational path from input to output is i_rdy -> o_rdy; there is no path from i_vld or i_x to any output.
- Once o_vld is high, it stays high with stable o_idx, o_oh, o_seq, and o_last until the beat handshake completes.

## Test plan
- W=8, FROM_LSB=0, i_x=8'b1010_0100, i_rdy=1:
  - beats idx 7,5,2 with seq 0,1,2 in cycles 1,2,3;
  - o_last only on idx 2;
  - o_rdy low in cycles 1-2 and high in cycle 3.
- W=8, FROM_LSB=1, i_x=8'b1010_0100: beats idx 2,5,7 with o_oh 8'h04, 8'h20, 8'h80.
- Backpressure: i_x=8'hC0 with i_rdy=0 for cycles 1-3. idx=7, seq=0, o_last=0 held stable through cycle 3. After i_rdy rises, idx 6 is emitted with o_last=1.
- Zero vector: i_x=8'h00 accepted. o_vld stays 0, o_rdy stays 1, and the next vector 8'h10 yields a single beat idx=4, seq=0, o_last=1.
- Back-to-back: i_x=8'h01 then 8'h80 with i_vld and i_rdy held high. Beats are idx 0 in cycle 1 and idx 7 in cycle 2, each with seq=0 and o_last=1, and there are no idle cycles between them.
- Reset mid-operation: i_x=8'hFF, and i_arst is asserted after beat idx 7. o_vld drops to 0 asynchronously and o_rdy reads 1. After reset release, i_x=8'h02 yields idx 1, seq 0, o_last=1, with no beats from the old vector.
